stack_irq_sequencer: RTL and testbench

//  Sequences the 16x10 return-address stack (push/pop/s_intr) between CPU call/ret/reti requests and

---
 rtl/stack_irq_sequencer_pkg.sv | 20 ++
 rtl/stack_irq_sequencer_irq_prio_enc.sv | 40 ++++
 rtl/stack_irq_sequencer.sv | 166 ++++++++++++++++
 tb/tb_stack_irq_sequencer.sv | 278 +++++++++++++++++++++++++++
 4 files changed

// File: rtl/stack_irq_sequencer_pkg.sv
`default_nettype none
// ============================================================================
//  Module      : stack_irq_sequencer_pkg
//  Description : Shared widths, stack geometry and sequencer state encoding.
//  Revision    : 1.0 - initial release
// ============================================================================
package stack_irq_sequencer_pkg;

    localparam int PC_W        = 10;
    localparam int STACK_DEPTH = 16;
    localparam int DEPTH_W     = $clog2(STACK_DEPTH);

    typedef enum logic [1:0] {
        ST_IDLE   = 2'd0,
        ST_ENTER  = 2'd1,
        ST_VECTOR = 2'd2
    } state_e;

endpackage
`default_nettype wire

// File: rtl/stack_irq_sequencer_irq_prio_enc.sv
`default_nettype none
// ============================================================================
//  Module      : irq_prio_enc
//  Description : Picks the highest-priority pending line that can pre-empt
//                whatever is currently in service (bit 0 = highest priority).
//  Revision    : 1.0 - initial release
// ============================================================================
module irq_prio_enc #(
    parameter int NIRQ  = 4,
    parameter int IDX_W = 2
) (
    input  logic [NIRQ-1:0]  pending_i,
    input  logic [NIRQ-1:0]  in_service_i,
    output logic             valid_o,
    output logic [IDX_W-1:0] index_o,
    output logic [NIRQ-1:0]  top_service_o
);

    logic [NIRQ-1:0] w_mask;
    logic [NIRQ-1:0] w_eligible;

    // Isolate the lowest set in-service bit; subtracting one yields every
    // strictly higher-priority line (all ones when nothing is in service).
    assign top_service_o = in_service_i & (~in_service_i + NIRQ'(1));
    assign w_mask        = top_service_o - NIRQ'(1);
    assign w_eligible    = pending_i & w_mask;

    always_comb begin
        valid_o = 1'b0;
        index_o = '0;
        for (int i = NIRQ - 1; i >= 0; i--) begin
            if (w_eligible[i]) begin
                valid_o = 1'b1;
                index_o = IDX_W'(i);
            end
        end
    end

endmodule
`default_nettype wire

// File: rtl/stack_irq_sequencer.sv
`default_nettype none
// ============================================================================
//  Module      : stack_irq_sequencer
//  Description : Arbitrates CALL/RET/RETI and prioritised interrupt entry onto
//                the return-address stack; tracks depth and over/underflow.
//  Revision    : 1.0 - initial release
// ============================================================================
module stack_irq_sequencer
    import stack_irq_sequencer_pkg::*;
#(
    parameter int              NIRQ       = 4,
    parameter logic [PC_W-1:0] VEC_BASE   = 10'h3C0,
    parameter int              VEC_STRIDE = 4,
    parameter int              CAPACITY   = 15
) (
    input  logic            clk,
    input  logic            reset,
    input  logic [NIRQ-1:0] irq,
    input  logic            call_req,
    input  logic            ret_req,
    input  logic            reti_req,
    input  logic [PC_W-1:0] pc_in,
    output logic            st_push,
    output logic            st_pop,
    output logic            st_intr,
    output logic [PC_W-1:0] st_dato,
    output logic            vec_load,
    output logic [PC_W-1:0] vec_addr,
    output logic            cpu_stall,
    output logic [NIRQ-1:0] irq_ack,
    output logic [DEPTH_W-1:0] depth,
    output logic            ovf,
    output logic            unf
);

    localparam int IDX_W = (NIRQ > 1) ? $clog2(NIRQ) : 1;

    state_e              state_q, state_d;
    logic [NIRQ-1:0]     pending_q, pending_d;
    logic [NIRQ-1:0]     in_service_q, in_service_d;
    logic [NIRQ-1:0]     irq_prev_q;
    logic [IDX_W-1:0]    idx_q, idx_d;
    logic [DEPTH_W-1:0]  depth_q, depth_d;
    logic                ovf_q, ovf_d;
    logic                unf_q, unf_d;

    logic [NIRQ-1:0]     w_irq_rise;
    logic                w_valid;
    logic [IDX_W-1:0]    w_index;
    logic [NIRQ-1:0]     w_top_service;
    logic                w_full;
    logic                w_empty;

    irq_prio_enc #(
        .NIRQ  (NIRQ),
        .IDX_W (IDX_W)
    ) u_prio (
        .pending_i     (pending_q),
        .in_service_i  (in_service_q),
        .valid_o       (w_valid),
        .index_o       (w_index),
        .top_service_o (w_top_service)
    );

    assign w_irq_rise = irq & ~irq_prev_q;
    assign w_full     = (depth_q == DEPTH_W'(CAPACITY));
    assign w_empty    = (depth_q == '0);

    // The stack adds one on push; RETI's s_intr strips it again on return.
    assign st_dato = pc_in;
    assign depth   = depth_q;
    assign ovf     = ovf_q;
    assign unf     = unf_q;

    always_comb begin
        state_d      = state_q;
        idx_d        = idx_q;
        depth_d      = depth_q;
        ovf_d        = ovf_q;
        unf_d        = unf_q;
        in_service_d = in_service_q;
        st_push      = 1'b0;
        st_pop       = 1'b0;
        st_intr      = 1'b0;
        vec_load     = 1'b0;
        vec_addr     = '0;
        cpu_stall    = 1'b0;
        irq_ack      = '0;

        case (state_q)
            ST_IDLE: begin
                if (call_req) begin
                    if (w_full) begin
                        ovf_d = 1'b1;
                    end else begin
                        st_push = 1'b1;
                        depth_d = depth_q + DEPTH_W'(1);
                    end
                end else if (ret_req || reti_req) begin
                    if (w_empty) begin
                        unf_d = 1'b1;
                    end else begin
                        st_pop  = 1'b1;
                        st_intr = reti_req;
                        depth_d = depth_q - DEPTH_W'(1);
                        if (reti_req) begin
                            in_service_d = in_service_q & ~w_top_service;
                        end
                    end
                end else if (w_valid) begin
                    state_d = ST_ENTER;
                    idx_d   = w_index;
                end
            end

            ST_ENTER: begin
                cpu_stall = 1'b1;
                // A full stack abandons the entry; the line stays pending.
                if (w_full) begin
                    ovf_d   = 1'b1;
                    state_d = ST_IDLE;
                end else begin
                    st_push = 1'b1;
                    depth_d = depth_q + DEPTH_W'(1);
                    state_d = ST_VECTOR;
                end
            end

            ST_VECTOR: begin
                vec_load            = 1'b1;
                vec_addr            = VEC_BASE + PC_W'(VEC_STRIDE) * PC_W'(idx_q);
                irq_ack[idx_q]      = 1'b1;
                in_service_d[idx_q] = 1'b1;
                state_d             = ST_IDLE;
            end

            default: state_d = ST_IDLE;
        endcase
    end

    assign pending_d = (pending_q & ~irq_ack) | w_irq_rise;

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            state_q      <= ST_IDLE;
            pending_q    <= '0;
            in_service_q <= '0;
            irq_prev_q   <= '0;
            idx_q        <= '0;
            depth_q      <= '0;
            ovf_q        <= 1'b0;
            unf_q        <= 1'b0;
        end else begin
            state_q      <= state_d;
            pending_q    <= pending_d;
            in_service_q <= in_service_d;
            irq_prev_q   <= irq;
            idx_q        <= idx_d;
            depth_q      <= depth_d;
            ovf_q        <= ovf_d;
            unf_q        <= unf_d;
        end
    end

endmodule
`default_nettype wire

// File: tb/tb_stack_irq_sequencer.sv
`default_nettype none
// ============================================================================
//  Module      : tb_stack_irq_sequencer
//  Description : Scoreboard bench for the stack/interrupt sequencer.
//  Revision    : 1.0 - initial release
// ============================================================================
module tb_stack_irq_sequencer;

    logic       clk = 1'b0;
    logic       reset;
    logic [3:0] irq;
    logic       call_req, ret_req, reti_req;
    logic [9:0] pc_in;
    logic       st_push, st_pop, st_intr, vec_load, cpu_stall, ovf, unf;
    logic [9:0] st_dato, vec_addr;
    logic [3:0] irq_ack, depth;

    typedef struct packed {
        logic [4:0] strb;   // push, pop, intr, vec_load, cpu_stall
        logic [3:0] ack;
        logic [9:0] vaddr;
        logic [9:0] dato;
        logic [3:0] depth;
        logic [1:0] flags;  // ovf, unf
    } obs_t;

    typedef struct {
        logic [3:0] irq;
        logic       call, ret, reti;
        logic [9:0] pc;
        obs_t       exp;
    } vec_t;

    obs_t sb[$];
    int   n_vec = 0;
    int   n_err = 0;

    stack_irq_sequencer dut (
        .clk       (clk),
        .reset     (reset),
        .irq       (irq),
        .call_req  (call_req),
        .ret_req   (ret_req),
        .reti_req  (reti_req),
        .pc_in     (pc_in),
        .st_push   (st_push),
        .st_pop    (st_pop),
        .st_intr   (st_intr),
        .st_dato   (st_dato),
        .vec_load  (vec_load),
        .vec_addr  (vec_addr),
        .cpu_stall (cpu_stall),
        .irq_ack   (irq_ack),
        .depth     (depth),
        .ovf       (ovf),
        .unf       (unf)
    );

    always #5 clk = ~clk;

    initial begin
        #200000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1);
    end

    function automatic obs_t sample();
        obs_t o;
        o = {st_push, st_pop, st_intr, vec_load, cpu_stall, irq_ack, vec_addr, st_dato, depth, ovf, unf};
        return o;
    endfunction

    // req = {call, ret, reti}
    function automatic vec_t V(input logic [3:0] i_irq, input logic [2:0] req, input logic [9:0] pc,
                               input logic [4:0] strb, input logic [3:0] ack, input logic [9:0] va,
                               input logic [3:0] d, input logic [1:0] fl);
        vec_t v;
        v.irq = i_irq;
        {v.call, v.ret, v.reti} = req;
        v.pc  = pc;
        v.exp = {strb, ack, va, pc, d, fl};
        return v;
    endfunction

    task automatic apply(input vec_t v);
        irq      = v.irq;
        call_req = v.call;
        ret_req  = v.ret;
        reti_req = v.reti;
        pc_in    = v.pc;
    endtask

    task automatic do_reset();
        @(posedge clk); #1;
        reset = 1'b1;
        apply(V(4'b0, 3'b000, 10'h0, 5'b0, 4'b0, 10'h0, 4'd0, 2'b00));
        @(posedge clk); #1;
        reset = 1'b0;
    endtask

    task automatic test_reset();
        obs_t o, e;
        vec_t stim[$];
        reset = 1'b1;
        apply(V(4'b0, 3'b000, 10'h0, 5'b0, 4'b0, 10'h0, 4'd0, 2'b00));
        sb.push_back('0);
        @(negedge clk);
        o = sample(); e = sb.pop_front(); n_vec++;
        if (o !== e) begin n_err++; $display("FAIL reset_held: got %h want %h", o, e); end
        @(posedge clk); #1;
        reset = 1'b0;
        stim.push_back(V(4'b0, 3'b000, 10'h155, 5'b0, 4'b0, 10'h0, 4'd0, 2'b00));
        stim.push_back(V(4'b0, 3'b000, 10'h2AA, 5'b0, 4'b0, 10'h0, 4'd0, 2'b00));
        foreach (stim[k]) begin
            @(posedge clk); #1;
            apply(stim[k]); sb.push_back(stim[k].exp);
            @(negedge clk);
            o = sample(); e = sb.pop_front(); n_vec++;
            if (o !== e) begin n_err++; $display("FAIL reset_idle[%0d]: got %h want %h", k, o, e); end
        end
    endtask

    task automatic test_call_ret();
        obs_t o, e;
        vec_t stim[$];
        do_reset();
        stim.push_back(V(4'b0, 3'b100, 10'h012, 5'b10000, 4'b0, 10'h0, 4'd0, 2'b00));
        stim.push_back(V(4'b0, 3'b010, 10'h013, 5'b01000, 4'b0, 10'h0, 4'd1, 2'b00));
        stim.push_back(V(4'b0, 3'b000, 10'h014, 5'b00000, 4'b0, 10'h0, 4'd0, 2'b00));
        foreach (stim[k]) begin
            @(posedge clk); #1;
            apply(stim[k]); sb.push_back(stim[k].exp);
            @(negedge clk);
            o = sample(); e = sb.pop_front(); n_vec++;
            if (o !== e) begin n_err++; $display("FAIL call_ret[%0d]: got %h want %h", k, o, e); end
        end
    endtask

    task automatic test_irq_nest();
        obs_t o, e;
        vec_t stim[$];
        do_reset();
        stim.push_back(V(4'b0100, 3'b000, 10'h040, 5'b00000, 4'b0000, 10'h000, 4'd0, 2'b00));
        stim.push_back(V(4'b0100, 3'b000, 10'h040, 5'b00000, 4'b0000, 10'h000, 4'd0, 2'b00));
        stim.push_back(V(4'b0100, 3'b000, 10'h040, 5'b10001, 4'b0000, 10'h000, 4'd0, 2'b00));
        stim.push_back(V(4'b0100, 3'b000, 10'h040, 5'b00010, 4'b0100, 10'h3C8, 4'd1, 2'b00));
        stim.push_back(V(4'b1100, 3'b000, 10'h3C8, 5'b00000, 4'b0000, 10'h000, 4'd1, 2'b00));
        stim.push_back(V(4'b1101, 3'b000, 10'h3C8, 5'b00000, 4'b0000, 10'h000, 4'd1, 2'b00));
        stim.push_back(V(4'b1101, 3'b000, 10'h3C9, 5'b00000, 4'b0000, 10'h000, 4'd1, 2'b00));
        stim.push_back(V(4'b1101, 3'b000, 10'h3C9, 5'b10001, 4'b0000, 10'h000, 4'd1, 2'b00));
        stim.push_back(V(4'b1101, 3'b000, 10'h3C9, 5'b00010, 4'b0001, 10'h3C0, 4'd2, 2'b00));
        stim.push_back(V(4'b1101, 3'b000, 10'h3C0, 5'b00000, 4'b0000, 10'h000, 4'd2, 2'b00));
        stim.push_back(V(4'b1101, 3'b001, 10'h3C1, 5'b01100, 4'b0000, 10'h000, 4'd2, 2'b00));
        stim.push_back(V(4'b1101, 3'b000, 10'h3C9, 5'b00000, 4'b0000, 10'h000, 4'd1, 2'b00));
        stim.push_back(V(4'b1101, 3'b001, 10'h3CA, 5'b01100, 4'b0000, 10'h000, 4'd1, 2'b00));
        stim.push_back(V(4'b1101, 3'b000, 10'h041, 5'b00000, 4'b0000, 10'h000, 4'd0, 2'b00));
        stim.push_back(V(4'b1101, 3'b000, 10'h041, 5'b10001, 4'b0000, 10'h000, 4'd0, 2'b00));
        stim.push_back(V(4'b1101, 3'b000, 10'h041, 5'b00010, 4'b1000, 10'h3CC, 4'd1, 2'b00));
        stim.push_back(V(4'b1101, 3'b000, 10'h3CC, 5'b00000, 4'b0000, 10'h000, 4'd1, 2'b00));
        foreach (stim[k]) begin
            @(posedge clk); #1;
            apply(stim[k]); sb.push_back(stim[k].exp);
            @(negedge clk);
            o = sample(); e = sb.pop_front(); n_vec++;
            if (o !== e) begin n_err++; $display("FAIL irq_nest[%0d]: got %h want %h", k, o, e); end
        end
    endtask

    task automatic test_call_vs_irq();
        obs_t o, e;
        vec_t stim[$];
        do_reset();
        stim.push_back(V(4'b0010, 3'b100, 10'h050, 5'b10000, 4'b0000, 10'h000, 4'd0, 2'b00));
        stim.push_back(V(4'b0010, 3'b000, 10'h051, 5'b00000, 4'b0000, 10'h000, 4'd1, 2'b00));
        stim.push_back(V(4'b0010, 3'b000, 10'h051, 5'b10001, 4'b0000, 10'h000, 4'd1, 2'b00));
        stim.push_back(V(4'b0010, 3'b000, 10'h051, 5'b00010, 4'b0010, 10'h3C4, 4'd2, 2'b00));
        stim.push_back(V(4'b0010, 3'b000, 10'h3C4, 5'b00000, 4'b0000, 10'h000, 4'd2, 2'b00));
        foreach (stim[k]) begin
            @(posedge clk); #1;
            apply(stim[k]); sb.push_back(stim[k].exp);
            @(negedge clk);
            o = sample(); e = sb.pop_front(); n_vec++;
            if (o !== e) begin n_err++; $display("FAIL call_vs_irq[%0d]: got %h want %h", k, o, e); end
        end
    endtask

    task automatic test_overflow();
        obs_t o, e;
        vec_t stim[$];
        do_reset();
        for (int i = 0; i < 15; i++) begin
            stim.push_back(V(4'b0, 3'b100, 10'h100 + 10'(i), 5'b10000, 4'b0, 10'h0, 4'(i), 2'b00));
        end
        stim.push_back(V(4'b0000, 3'b100, 10'h10F, 5'b00000, 4'b0000, 10'h000, 4'd15, 2'b00));
        stim.push_back(V(4'b0000, 3'b000, 10'h110, 5'b00000, 4'b0000, 10'h000, 4'd15, 2'b10));
        stim.push_back(V(4'b0001, 3'b000, 10'h110, 5'b00000, 4'b0000, 10'h000, 4'd15, 2'b10));
        stim.push_back(V(4'b0001, 3'b000, 10'h110, 5'b00000, 4'b0000, 10'h000, 4'd15, 2'b10));
        stim.push_back(V(4'b0001, 3'b000, 10'h110, 5'b00001, 4'b0000, 10'h000, 4'd15, 2'b10));
        stim.push_back(V(4'b0001, 3'b010, 10'h111, 5'b01000, 4'b0000, 10'h000, 4'd15, 2'b10));
        stim.push_back(V(4'b0001, 3'b000, 10'h112, 5'b00000, 4'b0000, 10'h000, 4'd14, 2'b10));
        stim.push_back(V(4'b0001, 3'b000, 10'h112, 5'b10001, 4'b0000, 10'h000, 4'd14, 2'b10));
        stim.push_back(V(4'b0001, 3'b000, 10'h112, 5'b00010, 4'b0001, 10'h3C0, 4'd15, 2'b10));
        foreach (stim[k]) begin
            @(posedge clk); #1;
            apply(stim[k]); sb.push_back(stim[k].exp);
            @(negedge clk);
            o = sample(); e = sb.pop_front(); n_vec++;
            if (o !== e) begin n_err++; $display("FAIL overflow[%0d]: got %h want %h", k, o, e); end
        end
    endtask

    task automatic test_underflow();
        obs_t o, e;
        vec_t stim[$];
        do_reset();
        stim.push_back(V(4'b0, 3'b010, 10'h020, 5'b00000, 4'b0, 10'h0, 4'd0, 2'b00));
        stim.push_back(V(4'b0, 3'b000, 10'h021, 5'b00000, 4'b0, 10'h0, 4'd0, 2'b01));
        stim.push_back(V(4'b0, 3'b001, 10'h022, 5'b00000, 4'b0, 10'h0, 4'd0, 2'b01));
        stim.push_back(V(4'b0, 3'b100, 10'h023, 5'b10000, 4'b0, 10'h0, 4'd0, 2'b01));
        stim.push_back(V(4'b0, 3'b000, 10'h024, 5'b00000, 4'b0, 10'h0, 4'd1, 2'b01));
        foreach (stim[k]) begin
            @(posedge clk); #1;
            apply(stim[k]); sb.push_back(stim[k].exp);
            @(negedge clk);
            o = sample(); e = sb.pop_front(); n_vec++;
            if (o !== e) begin n_err++; $display("FAIL underflow[%0d]: got %h want %h", k, o, e); end
        end
    endtask

    task automatic test_reset_mid_enter();
        obs_t o, e;
        vec_t stim[$];
        vec_t post[$];
        do_reset();
        stim.push_back(V(4'b0001, 3'b000, 10'h100, 5'b00000, 4'b0, 10'h0, 4'd0, 2'b00));
        stim.push_back(V(4'b0001, 3'b000, 10'h100, 5'b00000, 4'b0, 10'h0, 4'd0, 2'b00));
        stim.push_back(V(4'b0001, 3'b000, 10'h100, 5'b10001, 4'b0, 10'h0, 4'd0, 2'b00));
        foreach (stim[k]) begin
            @(posedge clk); #1;
            apply(stim[k]); sb.push_back(stim[k].exp);
            @(negedge clk);
            o = sample(); e = sb.pop_front(); n_vec++;
            if (o !== e) begin n_err++; $display("FAIL mid_enter[%0d]: got %h want %h", k, o, e); end
        end
        reset = 1'b1;
        irq   = 4'b0;
        sb.push_back(V(4'b0, 3'b000, 10'h100, 5'b0, 4'b0, 10'h0, 4'd0, 2'b00).exp);
        #1;
        o = sample(); e = sb.pop_front(); n_vec++;
        if (o !== e) begin n_err++; $display("FAIL mid_enter_async: got %h want %h", o, e); end
        @(posedge clk); #1;
        reset = 1'b0;
        for (int i = 0; i < 4; i++) begin
            post.push_back(V(4'b0, 3'b000, 10'h101 + 10'(i), 5'b0, 4'b0, 10'h0, 4'd0, 2'b00));
        end
        foreach (post[k]) begin
            @(posedge clk); #1;
            apply(post[k]); sb.push_back(post[k].exp);
            @(negedge clk);
            o = sample(); e = sb.pop_front(); n_vec++;
            if (o !== e) begin n_err++; $display("FAIL after_reset[%0d]: got %h want %h", k, o, e); end
        end
    endtask

    initial begin
        test_reset();
        test_call_ret();
        test_irq_nest();
        test_call_vs_irq();
        test_overflow();
        test_underflow();
        test_reset_mid_enter();
        $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
        $finish;
    end

endmodule
`default_nettype wire
